// File: rtl/dmem_run_controller.sv
// Data-memory port owner and run sequencer: arbitrates MemoryQ between the host loader
// and the core, issues the core start pulse and times each run.
module dmem_run_controller #(
    parameter int                   reg_width      = 12,
    parameter int                   addr_width     = 12,
    parameter int                   cnt_width      = 24,
    parameter logic [cnt_width-1:0] timeout_cycles = 24'd1000000,
    parameter int                   mem_latency    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  host_load_req,
    input  logic                  host_run,
    input  logic [addr_width-1:0] host_addr,
    input  logic [reg_width-1:0]  host_wdata,
    input  logic                  host_wren,
    input  logic                  host_rd_req,
    output logic [reg_width-1:0]  host_rdata,
    output logic                  host_rvalid,
    output logic                  host_reject,
    input  logic [addr_width-1:0] core_addr,
    input  logic [reg_width-1:0]  core_wdata,
    input  logic                  core_wren,
    input  logic                  core_done,
    output logic                  core_start,
    output logic                  core_hold,
    output logic [addr_width-1:0] mem_addr,
    output logic [reg_width-1:0]  mem_data,
    output logic                  mem_wren,
    input  logic [reg_width-1:0]  mem_q,
    output logic [1:0]            state,
    output logic [cnt_width-1:0]  cycle_count,
    output logic                  timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [cnt_width-1:0] timeout_last = timeout_cycles - cnt_width'(1);

    state_t                 state_q, state_d;
    logic                   core_start_q, core_start_d;
    logic                   core_hold_q, core_hold_d;
    logic                   timeout_q, timeout_d;
    logic [cnt_width-1:0]   cycle_count_q, cycle_count_d;
    logic                   host_rvalid_q, host_rvalid_d;
    logic                   host_reject_q, host_reject_d;
    logic [reg_width-1:0]   host_rdata_q, host_rdata_d;
    logic [mem_latency-1:0] rd_pipe_q, rd_pipe_d;
    logic                   rd_accept;

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        timeout_d     = timeout_q;
        cycle_count_d = cycle_count_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (host_run) begin
                    state_d = RUN;
                end else if (host_load_req) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (host_run) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (core_done) begin
                    state_d   = DONE;
                    timeout_d = 1'b0;
                end else if (cycle_count_q == timeout_last) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                end else if (cycle_count_q != '1) begin
                    cycle_count_d = cycle_count_q + cnt_width'(1);
                end
            end
        endcase

        if (state_d == RUN && state_q != RUN) begin
            cycle_count_d = '0;
            timeout_d     = 1'b0;
        end

        core_start_d = (state_d == RUN) && (state_q != RUN);
        core_hold_d  = (state_d != RUN);
    end

    // Reads issued before a RUN entry keep flowing through the pipe; the memory already
    // captured their address, so mem_q is still the right word when the pipe drains.
    always_comb begin
        rd_accept     = (state_q != RUN) && host_rd_req && !host_wren;
        rd_pipe_d     = (rd_pipe_q << 1) | mem_latency'(rd_accept);
        host_rvalid_d = rd_pipe_q[mem_latency-1];
        host_rdata_d  = host_rvalid_d ? mem_q : host_rdata_q;
        host_reject_d = (state_q == RUN) ? (host_wren || host_rd_req)
                                         : (host_wren && host_rd_req);
    end

    always_comb begin
        if (state_q == RUN) begin
            mem_addr = core_addr;
            mem_data = core_wdata;
            mem_wren = core_wren;
        end else begin
            mem_addr = host_addr;
            mem_data = host_wdata;
            mem_wren = host_wren && !reset;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            core_start_q  <= 1'b0;
            core_hold_q   <= 1'b1;
            timeout_q     <= 1'b0;
            cycle_count_q <= '0;
            host_rvalid_q <= 1'b0;
            host_reject_q <= 1'b0;
            host_rdata_q  <= '0;
            rd_pipe_q     <= '0;
        end else begin
            state_q       <= state_d;
            core_start_q  <= core_start_d;
            core_hold_q   <= core_hold_d;
            timeout_q     <= timeout_d;
            cycle_count_q <= cycle_count_d;
            host_rvalid_q <= host_rvalid_d;
            host_reject_q <= host_reject_d;
            host_rdata_q  <= host_rdata_d;
            rd_pipe_q     <= rd_pipe_d;
        end
    end

    assign state       = state_q;
    assign core_start  = core_start_q;
    assign core_hold   = core_hold_q;
    assign timeout     = timeout_q;
    assign cycle_count = cycle_count_q;
    assign host_rvalid = host_rvalid_q;
    assign host_reject = host_reject_q;
    assign host_rdata  = host_rdata_q;

endmodule
